// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//
// Takes parallel words over a valid/ready handshake and sends them out one
// bit per clock on a registered serial line (x_out), qualified by x_valid.
// When there is no payload the line sits at IDLE_LEVEL. If a new word is
// offered while the last bit of the current one is on the line, it is
// accepted and streamed right after, with no idle cycle in between.
//
// Parameters
//   WIDTH       bits per word (2..32)
//   MSB_FIRST   1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   IDLE_LEVEL  line level when no payload bit is present
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   din        parallel word, sampled only on an accepting edge
//   din_valid  din holds a word
//   din_ready  a word can be taken this cycle (combinational: flush, state)
//   flush      synchronous abort of the word in flight
//   x_out      registered serial bit
//   x_valid    registered, x_out carries a payload bit
//   word_done  registered pulse while the last bit of a word is on x_out
//   busy       registered, high while a word is being shifted out
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no word loaded, line at IDLE_LEVEL
// S_SHIFT | word on the line; cnt_q = send-order index of the bit on x_out

module serial_bit_feeder #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             flush,
    output logic             x_out,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               x_out_q, x_out_d;
    logic               x_valid_q, x_valid_d;
    logic               word_done_q, word_done_d;

    logic               last_bit;
    logic               accept;

    // Bit that goes out first from a word, given the send order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Drop the bit that was just sent so the next one sits at the front.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign last_bit  = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    assign din_ready = ~flush & ((state_q == S_IDLE) | last_bit);
    assign accept    = din_valid & din_ready;

    // The shift register holds the bits still to be sent; the bit on the
    // line is already in x_out_q, so a load stores the word advanced once.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        x_out_d   = IDLE_LEVEL;
        x_valid_d = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (accept) begin
            state_d   = S_SHIFT;
            cnt_d     = '0;
            shreg_d   = advance(din);
            x_out_d   = first_bit(din);
            x_valid_d = 1'b1;
        end else if (state_q == S_SHIFT) begin
            if (!last_bit) begin
                cnt_d     = cnt_q + CNT_W'(1);
                shreg_d   = advance(shreg_q);
                x_out_d   = first_bit(shreg_q);
                x_valid_d = 1'b1;
            end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        end

        // Pulse together with the bit whose send-order index is WIDTH-1.
        word_done_d = (state_d == S_SHIFT) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            x_out_q     <= IDLE_LEVEL;
            x_valid_q   <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            x_out_q     <= x_out_d;
            x_valid_q   <= x_valid_d;
            word_done_q <= word_done_d;
        end
    end

    assign x_out     = x_out_q;
    assign x_valid   = x_valid_q;
    assign word_done = word_done_q;
    assign busy      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_serial_bit_feeder.sv
module tb_serial_bit_feeder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic         flush;

    logic rdy_m, x_m, xv_m, wd_m, busy_m;
    logic rdy_l, x_l, xv_l, wd_l, busy_l;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .flush(flush), .x_out(x_m), .x_valid(xv_m),
        .word_done(wd_m), .busy(busy_m)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .flush(flush), .x_out(x_l), .x_valid(xv_l),
        .word_done(wd_l), .busy(busy_l)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the bits still to appear on the line, front = bit
    // currently shown. One queue per send order.
    logic qm[$];
    logic ql[$];
    logic rdy_m_s, rdy_l_s;

    function automatic logic model_ready();
        return !flush && (qm.size() <= 1);
    endfunction

    task automatic model_edge();
        if (!reset || flush) begin
            qm.delete();
            ql.delete();
        end else if (din_valid && qm.size() <= 1) begin
            qm.delete();
            ql.delete();
            for (int i = W - 1; i >= 0; i--) qm.push_back(din[i]);
            for (int i = 0; i < W; i++)      ql.push_back(din[i]);
        end else if (qm.size() > 0) begin
            void'(qm.pop_front());
            void'(ql.pop_front());
        end
    endtask

    task automatic model_check();
        logic em, el;
        em = (qm.size() > 0) ? qm[0] : 1'b0;
        el = (ql.size() > 0) ? ql[0] : 1'b0;
        check("x_out_msb", 32'(x_m), 32'(em));
        check("x_out_lsb", 32'(x_l), 32'(el));
        check("x_valid_msb", 32'(xv_m), 32'(qm.size() > 0));
        check("x_valid_lsb", 32'(xv_l), 32'(ql.size() > 0));
        check("word_done_msb", 32'(wd_m), 32'(qm.size() == 1));
        check("word_done_lsb", 32'(wd_l), 32'(ql.size() == 1));
        check("busy_msb", 32'(busy_m), 32'(qm.size() > 0));
        check("busy_lsb", 32'(busy_l), 32'(ql.size() > 0));
    endtask

    // One clock: drive inputs, check ready before the edge, advance the
    // model at the edge, check registered outputs just after it.
    task automatic cycle(input logic v, input logic f, input logic [W-1:0] d);
        din_valid = v;
        flush     = f;
        din       = d;
        @(negedge clk);
        rdy_m_s = rdy_m;
        rdy_l_s = rdy_l;
        check("din_ready_msb", 32'(rdy_m), 32'(model_ready()));
        check("din_ready_lsb", 32'(rdy_l), 32'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         xm;
        logic         xl;
        logic         xv;
        logic         wd;
        logic         busy;
        logic         rdy;
    } vec_t;

    vec_t vecs[$];

    // Seqs are written first-sent bit leftmost.
    task automatic add_word(input logic [W-1:0] d, input logic [W-1:0] seq_m,
                            input logic [W-1:0] seq_l, input logic nv,
                            input logic [W-1:0] nd);
        vec_t e;
        for (int k = 0; k < W; k++) begin
            e.v    = (k == 0) ? 1'b1 : nv;
            e.d    = (k == 0) ? d : nd;
            e.xm   = seq_m[W-1-k];
            e.xl   = seq_l[W-1-k];
            e.xv   = 1'b1;
            e.wd   = (k == W - 1);
            e.busy = 1'b1;
            e.rdy  = (k == 0);
            vecs.push_back(e);
        end
    endtask

    task automatic add_idle();
        vec_t e;
        e.v = 1'b0; e.d = '0; e.xm = 1'b0; e.xl = 1'b0;
        e.xv = 1'b0; e.wd = 1'b0; e.busy = 1'b0; e.rdy = 1'b1;
        vecs.push_back(e);
    endtask

    initial begin
        reset     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        flush     = 1'b0;

        // Reset values while held
        #12;
        check("rst_x_out", 32'(x_m), 32'd0);
        check("rst_x_valid", 32'(xv_m), 32'd0);
        check("rst_busy", 32'(busy_l), 32'd0);
        check("rst_word_done", 32'(wd_m), 32'd0);
        check("rst_din_ready", 32'(rdy_m), 32'd1);
        flush = 1'b1;
        #1;
        check("rst_din_ready_flush", 32'(rdy_l), 32'd0);
        flush = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Directed table
        add_word(8'hA5, 8'b10100101, 8'b10100101, 1'b0, 8'h00);
        add_idle();
        add_idle();
        add_word(8'hFF, 8'b11111111, 8'b11111111, 1'b1, 8'h00);
        add_word(8'h00, 8'b00000000, 8'b00000000, 1'b0, 8'h00);
        add_idle();
        add_word(8'h0D, 8'b00001101, 8'b10110000, 1'b0, 8'h00);
        add_idle();
        add_idle();

        foreach (vecs[i]) begin
            cycle(vecs[i].v, 1'b0, vecs[i].d);
            check($sformatf("vec%0d_ready", i), 32'(rdy_m_s), 32'(vecs[i].rdy));
            check($sformatf("vec%0d_xm", i), 32'(x_m), 32'(vecs[i].xm));
            check($sformatf("vec%0d_xl", i), 32'(x_l), 32'(vecs[i].xl));
            check($sformatf("vec%0d_xv", i), 32'(xv_l), 32'(vecs[i].xv));
            check($sformatf("vec%0d_wd", i), 32'(wd_m), 32'(vecs[i].wd));
            check($sformatf("vec%0d_busy", i), 32'(busy_m), 32'(vecs[i].busy));
        end

        // Flush on the third bit with a word pending
        cycle(1'b1, 1'b0, 8'hA5);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check("pre_flush_x_valid", 32'(xv_m), 32'd1);
        cycle(1'b1, 1'b1, 8'hC3);
        check("flush_ready_low", 32'(rdy_m_s), 32'd0);
        check("flush_x_valid", 32'(xv_m), 32'd0);
        check("flush_busy", 32'(busy_l), 32'd0);
        cycle(1'b1, 1'b0, 8'hC3);
        check("after_flush_accept_x", 32'(x_m), 32'd1);
        check("after_flush_busy", 32'(busy_m), 32'd1);
        for (int i = 0; i < W + 1; i++) cycle(1'b0, 1'b0, 8'h00);

        // Flush while idle does nothing
        cycle(1'b0, 1'b1, 8'h00);
        check("idle_flush_busy", 32'(busy_m), 32'd0);

        // Asynchronous reset mid-word
        cycle(1'b1, 1'b0, 8'hFF);
        cycle(1'b0, 1'b0, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        qm.delete();
        ql.delete();
        check("midrst_x_out", 32'(x_m), 32'd0);
        check("midrst_x_valid", 32'(xv_l), 32'd0);
        check("midrst_busy", 32'(busy_m), 32'd0);
        check("midrst_word_done", 32'(wd_l), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        check("post_rst_ready", 32'(rdy_l_s), 32'd1);
        check("post_rst_no_partial", 32'(xv_m), 32'd0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, W'($urandom));
        end
        for (int i = 0; i < W + 2; i++) cycle(1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_bit_feeder.md
# serial_bit_feeder

Upstream stage of the serial sequence detector: accepts parallel words over a valid/ready handshake and emits them one bit per clock on a registered serial line that drives the detector's `x` input. A `x_valid` qualifier marks cycles carrying payload bits. When idle, the line holds a fixed idle level. Back-to-back words stream with no bubble, so the detector sees a continuous bit stream.

## Interface
- `WIDTH`, 8: bits per word; legal range is 2 to 32.
- `MSB_FIRST`, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `IDLE_LEVEL`, 1'b0: value driven on `x_out` when no payload bit is present.

- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `din`  in  WIDTH  parallel word; sampled on an accepting edge.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  block can accept a word this cycle (combinational).
- `flush`  in  1  synchronous abort of the word in flight.
- `x_out`  out  1  registered serial bit; feeds the detector's `x`.
- `x_valid`  out  1  registered; high when `x_out` carries a payload bit.
- `word_done`  out  1  registered one-cycle pulse coincident with the last bit of a word.
- `busy`  out  1  high while in SHIFT.

## Operation
- **States:**
  - IDLE: no word loaded.
  - SHIFT: a word is being emitted; a bit counter `cnt` runs 0..WIDTH-1.
- **Accept condition:** `din_valid & din_ready` at a rising edge.
- **`din_ready`:** `~flush & (state==IDLE | (state==SHIFT & cnt==WIDTH-1))`. The block can therefore take a new word in the cycle its last bit is on the line.
- **IDLE → SHIFT on accept:**
  - The shift register loads `din`.
  - `cnt` goes to 0.
  - The first bit appears on `x_out` in the next cycle.
- **SHIFT with `cnt < WIDTH-1`:**
  - Next bit goes to `x_out`.
  - `cnt` increments.
  - `x_valid` stays 1.
- **SHIFT with `cnt == WIDTH-1`:**
  - If accept: reload `din`, `cnt` goes to 0, stay in SHIFT, and the new word's first bit follows with no gap.
  - Otherwise: go to IDLE, and `x_out` returns to IDLE_LEVEL with `x_valid` at 0 on the next cycle.
- **`word_done`:** 1 exactly in the cycle `x_out` presents bit index WIDTH-1 of the send order.
- **`flush` (highest priority):**
  - Next state is IDLE and `cnt` goes to 0.
  - Next cycle: `x_out` = IDLE_LEVEL, `x_valid` = 0, `word_done` = 0.
  - A `din_valid` in the same cycle is not accepted.
  - `flush` while in IDLE has no effect.
- **`din_valid` without ready:** the word is held by the source. The block does not sample `din` outside accept edges.
- **Counter width:** `$clog2(WIDTH)`. It never exceeds WIDTH-1, and wrap-around happens only through the reload path.

## Timing
- **Reset (asynchronous, while `reset`=0):**
  - State = IDLE, `cnt` = 0, shift register = 0.
  - `x_out` = IDLE_LEVEL, `x_valid` = 0, `word_done` = 0, `busy` = 0.
  - `din_ready` = 1, unless `flush`=1.
- **Reset mid-word:** the word is dropped immediately. There is no partial output after release.
- **Latency:** an accept at edge E puts bit 0 of the send order on `x_out` after E. The word occupies exactly WIDTH consecutive cycles.
- **Throughput:**
  - One bit per clock.
  - Sustained streaming with `din_valid` held high gives `x_valid` = 1 continuously.
  - `word_done` fires every WIDTH cycles.
- **Outputs:**
  - All outputs except `din_ready` are registered.
  - `din_ready` depends combinationally on `flush` and state only, not on `din_valid`.

## Test plan
- **Reset values:** assert `reset`=0 mid-stream → same cycle: `x_out`=0, `x_valid`=0, `busy`=0, `word_done`=0. After release, `din_ready`=1.
- **Single word, MSB first:** WIDTH=8, MSB_FIRST=1, accept `din`=8'hA5 at edge E → `x_out` = 1,0,1,0,0,1,0,1 over cycles E+1..E+8. `x_valid`=1 for those 8 cycles. `word_done`=1 only in E+8. `x_out`=0 and `x_valid`=0 at E+9.
- **LSB first:** MSB_FIRST=0, `din`=8'h0D → `x_out` = 1,0,1,1,0,0,0,0. `din_ready`=0 during E+1..E+7 and 1 at E+8.
- **Back-to-back:** `din_valid` held 1 with 8'hFF then 8'h00 → 8 ones immediately followed by 8 zeros with no idle cycle. `word_done` at E+8 and E+16. `busy` stays 1 throughout.
- **Flush:** `flush`=1 at the cycle showing the third bit of 8'hA5, with `din_valid`=1 → next cycle IDLE, `x_valid`=0, `word_done` never pulses, and the pending word is not consumed. It is accepted on the following cycle once `flush`=0.
- **End-to-end with detector:** stream the pattern 0,1,1 with IDLE_LEVEL=0 into the detector's `x`, `clk` and `reset` → the detector's `y` asserts in the cycle `x_out` presents the final 1, and in no other cycle.
